spi_cfg_responder: RTL and testbench
====================================

SPI_CFG_RESPONDER -- requirements
Module: spi_cfg_responder

Interface
REQ-001 Parameter WORDSIZE, default 16, bits per SPI frame.
REQ-002 Parameter ADDRBITS, default 7, register address field width, in word bits [15:9].
REQ-003 Parameter DATABITS, default 9, register data field width, in word bits [8:0]; WORDSIZE SHALL equal ADDRBITS+DATABITS.
REQ-004 Parameter NREGS, default 16, number of shadow registers.
REQ-005 clk  input  1  system clock; the only clock; rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 spi_sck  input  1  SPI clock from external initiator; CPOL=0, CPHA=0; asynchronous to clk.
REQ-008 spi_mosi  input  1  serial data in, MSB first.
REQ-009 cs  input  1  chip select, active low.
REQ-010 spi_miso  output  1  serial data out, MSB first.
REQ-011 wr_valid  output  1  one-clk pulse on a committed register write.
REQ-012 wr_addr  output  ADDRBITS  address of the last committed write; held until the next commit.
REQ-013 wr_data  output  DATABITS  data of the last committed write; held until the next commit.
REQ-014 err  output  1  one-clk pulse on a rejected frame.
REQ-015 rd_addr  input  log2(NREGS)  shadow register read address.
REQ-016 rd_data  output  DATABITS  contents of shadow register rd_addr; combinational read.

Function
REQ-017 spi_sck, spi_mosi and cs SHALL each pass through a 2-flop synchronizer, followed by one edge-detect register; clk SHALL be at least 8x the spi_sck frequency.
REQ-018 FSM states: IDLE, SHIFT, COMMIT.
REQ-019 IDLE->SHIFT on a synchronized cs falling edge; the bit counter and shift register clear on that edge.
REQ-020 SHIFT: on each synchronized spi_sck rising edge, shift the synchronized spi_mosi into the LSB and increment the bit counter; the counter saturates at WORDSIZE+1.
REQ-021 SHIFT->COMMIT on a synchronized cs rising edge; COMMIT->IDLE unconditionally after one clk.
REQ-022 COMMIT with count==WORDSIZE and address<NREGS: write the shadow register, update wr_addr/wr_data, pulse wr_valid.
REQ-023 COMMIT with count!=WORDSIZE (short or overrun frame) or address>=NREGS: no register write, wr_addr/wr_data unchanged, pulse err.
REQ-024 wr_valid and err SHALL go high exactly 4 clk cycles after cs rises at the port, given the input meets setup; they are never high together.
REQ-025 Readback: at the cs falling edge, a MISO shift register loads the last successfully received 16-bit word (0 after reset).
REQ-026 The MISO shift register drives spi_miso from its MSB and shifts left on each synchronized spi_sck falling edge; spi_miso is 0 while cs is high.
REQ-027 A commit and a same-cycle rd_addr read of the same register SHALL return the old value; the new value is returned from the next cycle.
REQ-028 spi_sck edges while in IDLE SHALL be ignored.

Reset
REQ-029 Reset asserted SHALL immediately set: FSM to IDLE; counter, shift registers, wr_addr, wr_data, all shadow registers and the last-word register to 0; spi_miso, wr_valid and err to 0.
REQ-030 Reset in mid-frame SHALL abort the frame with no write and no err pulse.
REQ-031 If cs is low when reset deasserts, the block SHALL stay in IDLE until cs is seen high and then low again.

Verification
REQ-032 Frame 0x0E12 (16 bits) -> wr_valid pulse 4 clk after cs rises; wr_addr=0x07, wr_data=0x012; rd_addr=7 gives rd_data=0x012.
REQ-033 15-bit frame, then 17-bit frame -> err pulse for each; no wr_valid; all shadow registers unchanged.
REQ-034 Frame with address 0x20 (word 0x4055) -> err pulse; rd_data unchanged for all rd_addr.
REQ-035 Frame 0x0E12, then frame 0x1234 -> spi_miso bits during the second frame read back 0x0E12 MSB first.
REQ-036 Reset after 8 bits of a frame -> all outputs 0, no pulses; the next full frame 0x0201 -> wr_addr=0x01, wr_data=0x001.
REQ-037 Reset deasserted with cs low, then 16 sck pulses and cs high -> no wr_valid and no err.

Source files
------------

// File: rtl/spi_cfg_responder.sv
// rtl/spi_cfg_responder.sv - SPI (mode 0) responder writing a bank of shadow config registers
// Oversampled in the clk domain; each frame carries {address, data}, and the last good word is read back on MISO.
module spi_cfg_responder #(
  parameter int WORDSIZE = 16,
  parameter int ADDRBITS = 7,
  parameter int DATABITS = 9,
  parameter int NREGS    = 16,
  localparam int RAW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spi_sck,
  input  logic                spi_mosi,
  input  logic                cs,
  output logic                spi_miso,
  output logic                wr_valid,
  output logic [ADDRBITS-1:0] wr_addr,
  output logic [DATABITS-1:0] wr_data,
  output logic                err,
  input  logic [RAW-1:0]      rd_addr,
  output logic [DATABITS-1:0] rd_data
);

  localparam int CW = $clog2(WORDSIZE + 2);
  localparam logic [CW-1:0] FULL = CW'(WORDSIZE);
  localparam logic [CW-1:0] OVER = CW'(WORDSIZE + 1);
  localparam logic [ADDRBITS:0] NREGS_W = (ADDRBITS + 1)'(NREGS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t state, state_nxt;

  logic [2:0] sck_q, cs_q;
  logic [1:0] mosi_q;
  logic [CW-1:0] count;
  logic [WORDSIZE-1:0] shift, miso_sr, last_word;
  logic [DATABITS-1:0] regs [NREGS];

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
  logic start, do_write, do_err, addr_ok;
  logic [ADDRBITS-1:0] frame_addr;
  logic [DATABITS-1:0] frame_data;

  // Stage 0/1 synchronize; stage 2 is the previous value for edge detection.
  // cs syncs reset low so a cs held low across reset never looks like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q  <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      cs_q   <= {cs_q[1:0], cs};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign mosi_s   = mosi_q[1];

  assign frame_addr = shift[WORDSIZE-1:DATABITS];
  assign frame_data = shift[DATABITS-1:0];
  assign addr_ok    = ({1'b0, frame_addr} < NREGS_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    do_write = 1'b0;
    do_err   = 1'b0;
    case (state)
      IDLE:    start = cs_fall;
      COMMIT: begin
        do_write = (count == FULL) && addr_ok;
        do_err   = !((count == FULL) && addr_ok);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      shift     <= '0;
      miso_sr   <= '0;
      last_word <= '0;
      wr_valid  <= 1'b0;
      err       <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wr_valid <= do_write;
      err      <= do_err;
      if (start) begin
        count   <= '0;
        shift   <= '0;
        miso_sr <= last_word;
      end else if (state == SHIFT) begin
        if (sck_rise) begin
          shift <= {shift[WORDSIZE-2:0], mosi_s};
          if (count != OVER) count <= count + 1'b1;
        end
        if (sck_fall) miso_sr <= {miso_sr[WORDSIZE-2:0], 1'b0};
      end
      if (do_write) begin
        wr_addr   <= frame_addr;
        wr_data   <= frame_data;
        last_word <= shift;
        regs[frame_addr[RAW-1:0]] <= frame_data;
      end
    end
  end

  assign spi_miso = ~cs & miso_sr[WORDSIZE-1];
  assign rd_data  = (32'(rd_addr) < NREGS) ? regs[rd_addr] : '0;

endmodule

// File: tb/tb_spi_cfg_responder.sv
// tb/tb_spi_cfg_responder.sv - directed and randomized frames checked against a register-bank model
module tb_spi_cfg_responder;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       cs = 1'b1;
  logic       spi_miso;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       err;
  logic [3:0] rd_addr = '0;
  logic [8:0] rd_data;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int nv = 0;
  int ne = 0;

  logic [8:0]  m_regs [16];
  logic [15:0] m_last;
  logic [6:0]  m_addr;
  logic [8:0]  m_data;

  spi_cfg_responder dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .cs(cs),
    .spi_miso(spi_miso), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_valid === 1'b1) nv++;
    if (err === 1'b1) ne++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_last = '0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check($sformatf("%s_rd%0d", tag, i), 32'(rd_data), 32'(m_regs[i]));
    end
  endtask

  task automatic do_frame(input logic [31:0] w, input int n, input string tag);
    logic [31:0] cap;
    logic [7:0]  wv, er;
    logic [15:0] prev;
    logic [31:0] exp_cap;
    int a, v0, e0;
    bit ok;
    prev = m_last;
    a  = int'((w >> 9) & 32'h7f);
    ok = (n == 16) && (a < 16);
    exp_cap = (n >= 16) ? (32'(prev) << (n - 16)) : (32'(prev) >> (16 - n));
    cap = '0;
    v0 = nv;
    e0 = ne;
    cs = 1'b0;
    repeat (6) @(posedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = w[i];
      #(HALF);
      spi_sck = 1'b1;
      cap = {cap[30:0], spi_miso};
      #(HALF);
      spi_sck = 1'b0;
    end
    #(HALF);
    @(posedge clk);
    #1 cs = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      wv[k] = wr_valid;
      er[k] = err;
    end
    if (ok) begin
      m_regs[a] = w[8:0];
      m_addr = 7'(a);
      m_data = w[8:0];
      m_last = w[15:0];
    end
    check({tag, "_wr_pulse"}, 32'(wv), ok ? 32'h08 : 32'h00);
    check({tag, "_err_pulse"}, 32'(er), ok ? 32'h00 : 32'h08);
    check({tag, "_pulse_cnt"}, 32'((nv - v0) + (ne - e0)), 32'd1);
    check({tag, "_miso"}, cap, exp_cap);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'(m_addr));
    check({tag, "_wr_data"}, 32'(wr_data), 32'(m_data));
  endtask

  initial begin
    logic [31:0] w;
    int n, v0, e0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check_regs("rst");

    do_frame(32'h0E12, 16, "f0e12");
    rd_addr = 4'd7;
    #1 check("f0e12_rd7", 32'(rd_data), 32'h012);
    do_frame(32'h1234, 16, "f1234");
    do_frame(32'($urandom_range(0, 32'h7fff)), 15, "short15");
    do_frame(32'($urandom_range(0, 32'h1ffff)), 17, "over17");
    check_regs("after_bad_len");
    do_frame(32'h4055, 16, "addr20");
    check_regs("after_bad_addr");

    for (int t = 0; t < 20; t++) begin
      w = {23'd0, 9'($urandom)};
      w[15:9] = 7'($urandom_range(0, 23));
      case ($urandom_range(0, 4))
        0: n = 15;
        1: n = 17;
        default: n = 16;
      endcase
      if (n == 17) w[16] = 1'($urandom);
      do_frame(w, n, $sformatf("rnd%0d", t));
    end
    check_regs("after_rnd");

    // reset partway through a frame
    cs = 1'b0;
    repeat (6) @(posedge clk);
    for (int i = 15; i >= 8; i--) begin
      spi_mosi = 1'b1;
      #(HALF) spi_sck = 1'b1;
      #(HALF) spi_sck = 1'b0;
    end
    v0 = nv;
    e0 = ne;
    #23 reset = 1'b1;
    #1;
    model_reset();
    check("midrst_miso", 32'(spi_miso), 32'd0);
    check("midrst_wr_valid", 32'(wr_valid), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_wr_data", 32'(wr_data), 32'd0);
    cs = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("midrst_no_pulse", 32'((nv - v0) + (ne - e0)), 32'd0);
    check_regs("midrst");
    do_frame(32'h0201, 16, "f0201");

    // reset released while cs is already low
    @(negedge clk) reset = 1'b1;
    cs = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    model_reset();
    v0 = nv;
    e0 = ne;
    repeat (6) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      spi_mosi = 1'($urandom);
      #(HALF) spi_sck = 1'b1;
      #(HALF) spi_sck = 1'b0;
    end
    #(HALF) cs = 1'b1;
    repeat (12) @(posedge clk);
    #1 check("cslow_no_pulse", 32'((nv - v0) + (ne - e0)), 32'd0);
    check("cslow_wr_addr", 32'(wr_addr), 32'd0);
    check_regs("cslow");
    do_frame({16'd0, 7'($urandom_range(0, 15)), 9'($urandom)}, 16, "recover");
    check_regs("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
